// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// RV_ILLEGAL_TRAP_EN adds the TRAP state to the state enum.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI
`ifdef RV_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // Which decoding rule the ALU decoder applies in the current state.
    typedef enum logic [1:0] {
        ALU_CLASS_ADD, ALU_CLASS_ARITH, ALU_CLASS_BRANCH, ALU_CLASS_JALR
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_JALR = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU operation decode from funct fields and the state's decode class.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  alu_class_t alu_class_i,
    output logic [3:0] alu_control_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        unique case (alu_class_i)
            ALU_CLASS_ARITH: begin
                // op[5] separates R-type from I-type: only R-type may subtract.
                unique case (funct3_i)
                    3'b000: alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control_o = ALU_SLL;
                    3'b010: alu_control_o = ALU_SLT;
                    3'b011: alu_control_o = ALU_SLTU;
                    3'b100: alu_control_o = ALU_XOR;
                    3'b101: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            ALU_CLASS_BRANCH: begin
                case (funct3_i)
                    3'b000:  alu_control_o = ALU_SUB;
                    3'b001:  alu_control_o = ALU_BNE;
                    3'b100:  alu_control_o = ALU_BLT;
                    3'b101:  alu_control_o = ALU_BGE;
                    3'b110:  alu_control_o = ALU_BLTU;
                    3'b111:  alu_control_o = ALU_BGEU;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            ALU_CLASS_JALR: alu_control_o = ALU_JALR;
            default:        alu_control_o = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/riscv_mc_controller.sv
// Moore-style multicycle RISC-V control FSM. Define RV_ILLEGAL_TRAP_EN to make
// illegal instructions lock in a TRAP state; otherwise they are skipped.
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal,
    output state_t     state_o
);
`ifdef RV_ILLEGAL_TRAP_EN
    localparam state_t S_ILLEGAL_NEXT = S_TRAP;
    logic illegal_c;
`else
    localparam state_t S_ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     state_q, state_d;
    alu_class_t alu_class;
    logic       mem_rdy;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    assign mem_rdy = WAIT_MEM ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ResultSrc   = RES_ALUOUT;
        alu_class   = ALU_CLASS_ADD;
`ifdef RV_ILLEGAL_TRAP_EN
        illegal_c   = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                ir_write_c = mem_rdy;
                pc_write_c = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_BRANCH: state_d = branch_f3_legal(funct3) ? S_BRANCH : S_ILLEGAL_NEXT;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_ALUWB;
                    default:   state_d = S_ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_RDATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                alu_class = ALU_CLASS_ARITH;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALU_CLASS_ARITH;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                alu_class  = ALU_CLASS_BRANCH;
                pc_write_c = Zero;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALU_CLASS_JALR;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // ALUOut holds the target; ALU computes the link address PC+4.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
`ifdef RV_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_c = 1'b1;
                state_d   = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:         ImmSrc = IMM_S;
            OP_BRANCH:        ImmSrc = IMM_B;
            OP_JAL:           ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
            default:          ImmSrc = IMM_I;
        endcase
    end

    riscv_alu_decoder u_alu_dec (
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_class_i   (alu_class),
        .alu_control_o (ALUControl)
    );

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    assign PCWrite  = pc_write_c  & rst_n;
    assign IRWrite  = ir_write_c  & rst_n;
    assign MemWrite = mem_write_c & rst_n;
    assign RegWrite = reg_write_c & rst_n;
`ifdef RV_ILLEGAL_TRAP_EN
    assign Illegal  = illegal_c & rst_n;
`else
    assign Illegal  = 1'b0;
`endif
    assign state_o  = state_q;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: walks instruction classes state by state.
module tb_riscv_mc_controller;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    state_t     state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    riscv_mc_controller #(.WAIT_MEM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .state_o(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(state_dbg), 32'(exp));
    endtask

    // Driver tasks: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // From FETCH: expects FETCH now, advances into DECODE then into the execute state.
    task automatic fetch_decode(input string tag, input state_t exec_st);
        check_state({tag, "_fetch"}, S_FETCH);
        tick();
        check_state({tag, "_decode"}, S_DECODE);
        tick();
        check_state({tag, "_exec"}, exec_st);
    endtask

    initial begin
        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        tick(); tick();
        // Reset state: strobes held low even though MemReady=1 in FETCH.
        check_state("rst_state", S_FETCH);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        check("fetch_irwrite", 32'(IRWrite), 32'd1);
        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
        check("fetch_srcb", 32'(ALUSrcB), 32'b10);
        check("fetch_result", 32'(ResultSrc), 32'b10);
        tick();

        // add x3,x1,x2
        check_state("add_decode", S_DECODE);
        check("add_dec_srca", 32'(ALUSrcA), 32'b01);
        check("add_dec_srcb", 32'(ALUSrcB), 32'b01);
        check("add_dec_regwrite", 32'(RegWrite), 32'd0);
        tick();
        check_state("add_exec", S_EXECUTER);
        check("add_aluctl", 32'(ALUControl), 32'b0000);
        check("add_srca", 32'(ALUSrcA), 32'b10);
        check("add_srcb", 32'(ALUSrcB), 32'b00);
        check("add_exec_regwrite", 32'(RegWrite), 32'd0);
        tick();
        check_state("add_aluwb", S_ALUWB);
        check("add_wb_regwrite", 32'(RegWrite), 32'd1);
        tick();

        // sub: R-type funct7b5=1
        set_instr(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub", S_EXECUTER);
        check("sub_aluctl", 32'(ALUControl), 32'b0001);
        tick(); tick();

        // addi with Instr[30] set still adds
        set_instr(7'b0010011, 3'b000, 1'b1);
        fetch_decode("addi", S_EXECUTEI);
        check("addi_aluctl", 32'(ALUControl), 32'b0000);
        check("addi_srcb", 32'(ALUSrcB), 32'b01);
        check("addi_imm", 32'(ImmSrc), 32'b000);
        tick(); tick();

        // srai
        set_instr(7'b0010011, 3'b101, 1'b1);
        fetch_decode("srai", S_EXECUTEI);
        check("srai_aluctl", 32'(ALUControl), 32'b1001);
        tick(); tick();

        // lw with a 3-cycle memory stall
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lw", S_MEMADR);
        check("lw_memadr_srca", 32'(ALUSrcA), 32'b10);
        MemReady = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_state($sformatf("lw_wait%0d", i), S_MEMREAD);
            check($sformatf("lw_wait%0d_adrsrc", i), 32'(AdrSrc), 32'd1);
            check($sformatf("lw_wait%0d_regwrite", i), 32'(RegWrite), 32'd0);
            tick();
        end
        check_state("lw_wait3", S_MEMREAD);
        MemReady = 1'b1;
        tick();
        check_state("lw_memwb", S_MEMWB);
        check("lw_wb_regwrite", 32'(RegWrite), 32'd1);
        check("lw_wb_result", 32'(ResultSrc), 32'b01);
        tick();
        check_state("lw_back_fetch", S_FETCH);
        check("lw_after_regwrite", 32'(RegWrite), 32'd0);

        // bge taken and not taken
        set_instr(7'b1100011, 3'b101, 1'b0);
        Zero = 1'b1;
        fetch_decode("bge_t", S_BRANCH);
        check("bge_t_aluctl", 32'(ALUControl), 32'b1101);
        check("bge_t_pcwrite", 32'(PCWrite), 32'd1);
        check("bge_imm", 32'(ImmSrc), 32'b010);
        tick();
        Zero = 1'b0;
        fetch_decode("bge_n", S_BRANCH);
        check("bge_n_pcwrite", 32'(PCWrite), 32'd0);
        tick();

        // jalr
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_decode("jalr", S_JALR);
        check("jalr_aluctl", 32'(ALUControl), 32'b0100);
        tick();
        check_state("jalr_jal", S_JAL);
        check("jalr_jal_pcwrite", 32'(PCWrite), 32'd1);
        check("jalr_jal_aluctl", 32'(ALUControl), 32'b0000);
        tick();
        check_state("jalr_aluwb", S_ALUWB);
        check("jalr_wb_regwrite", 32'(RegWrite), 32'd1);
        tick();

        // lui
        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui", S_LUI);
        check("lui_srca", 32'(ALUSrcA), 32'b11);
        check("lui_imm", 32'(ImmSrc), 32'b100);
        tick(); tick();

        // illegal branch funct3 and illegal opcode
        set_instr(7'b1100011, 3'b010, 1'b0);
`ifdef RV_ILLEGAL_TRAP_EN
        fetch_decode("bad_f3", S_TRAP);
        check("bad_f3_illegal", 32'(Illegal), 32'd1);
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
`else
        fetch_decode("bad_f3", S_FETCH);
        check("bad_f3_illegal", 32'(Illegal), 32'd0);
`endif
        set_instr(7'b1111111, 3'b000, 1'b0);
`ifdef RV_ILLEGAL_TRAP_EN
        fetch_decode("ill_op", S_TRAP);
        check("ill_op_illegal", 32'(Illegal), 32'd1);
        check("ill_op_irwrite", 32'(IRWrite), 32'd0);
        tick();
        check_state("ill_op_hold", S_TRAP);
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
`else
        fetch_decode("ill_op", S_FETCH);
        check("ill_op_illegal", 32'(Illegal), 32'd0);
        check("ill_op_regwrite", 32'(RegWrite), 32'd0);
`endif

        // sw, reset asserted mid-MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("sw", S_MEMADR);
        check("sw_imm", 32'(ImmSrc), 32'b001);
        MemReady = 1'b0;
        tick();
        check_state("sw_memwrite", S_MEMWRITE);
        check("sw_memwrite_strobe", 32'(MemWrite), 32'd1);
        tick();
        check("sw_memwrite_hold", 32'(MemWrite), 32'd1);
        MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        check_state("sw_rst_state", S_FETCH);
        check("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        check("sw_rst_irwrite", 32'(IRWrite), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("sw_rel_irwrite", 32'(IRWrite), 32'd1);
        tick();
        check_state("sw_rel_decode", S_DECODE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog keeps the run bounded even if the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
